// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: test-pattern source feeding the hdmi encoder core.
// Builds rgb from the core's cx/cy counters and screen/frame geometry.
//
// Ports:
//   clk_pixel, reset (async, active-high)
//   cx, cy          current pixel position from the hdmi core
//   screen_width/height, frame_width/height  active and total geometry
//   mode            requested pattern, latched at each frame end
//   rgb             registered pixel colour {R,G,B}, one cycle after cx/cy
//   frame_cnt       completed-frame counter (wraps)
//   mode_active     pattern currently displayed
//
// Optional: define HDMI_PATTERN_GEN_CROSSHAIR_EN to overlay a white
// centre crosshair on the active area in every mode.
module hdmi_pattern_gen #(
    parameter int          BIT_WIDTH  = 11,
    parameter int          BIT_HEIGHT = 10,
    parameter logic [23:0] SOLID_RGB  = 24'hFF0000,
    parameter int          BAR_W      = 160,
    parameter int          BAND_H     = 240,
    parameter int          CHECK_LOG2 = 5,
    parameter int          BOX_SIZE   = 64,
    parameter int          BOX_STEP   = 4
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    input  logic [BIT_WIDTH-1:0]  cx,
    input  logic [BIT_HEIGHT-1:0] cy,
    input  logic [BIT_WIDTH-1:0]  screen_width,
    input  logic [BIT_HEIGHT-1:0] screen_height,
    input  logic [BIT_WIDTH-1:0]  frame_width,
    input  logic [BIT_HEIGHT-1:0] frame_height,
    input  logic [2:0]            mode,
    output logic [23:0]           rgb,
    output logic [15:0]           frame_cnt,
    output logic [2:0]            mode_active
);

    localparam int BCW = $clog2(BAR_W + 1);
    localparam int WX  = BIT_WIDTH + 1;
    localparam int WY  = BIT_HEIGHT + 1;

    logic [23:0]           rgb_q, rgb_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [2:0]            mode_active_q, mode_active_d;
    logic [BIT_WIDTH-1:0]  box_x_q, box_x_d;
    logic [BIT_HEIGHT-1:0] box_y_q, box_y_d;
    // direction: 0 = increasing, 1 = decreasing
    logic                  dir_x_q, dir_x_d;
    logic                  dir_y_q, dir_y_d;
    logic [BCW-1:0]        bar_cnt_q, bar_cnt_d;
    logic [2:0]            bar_idx_q, bar_idx_d;

    logic                  frame_end;
    logic                  active;
    logic                  in_box;
    logic [WX-1:0]         cx_e, box_x_e, sw_e;
    logic [WY-1:0]         cy_e, box_y_e, sh_e;
    logic [23:0]           bar_rgb;
    logic [23:0]           pat;

    always_comb begin
        frame_end = (cx == frame_width - BIT_WIDTH'(1))
                 && (cy == frame_height - BIT_HEIGHT'(1));
        active    = (cx < screen_width) && (cy < screen_height);

        cx_e    = {1'b0, cx};
        cy_e    = {1'b0, cy};
        box_x_e = {1'b0, box_x_q};
        box_y_e = {1'b0, box_y_q};
        sw_e    = {1'b0, screen_width};
        sh_e    = {1'b0, screen_height};

        in_box = (cx_e >= box_x_e) && (cx_e < box_x_e + WX'(BOX_SIZE))
              && (cy_e >= box_y_e) && (cy_e < box_y_e + WY'(BOX_SIZE));
    end

    // Bar position is taken from the next-state values so that the
    // colour for pixel cx already reflects the bar that pixel falls in.
    always_comb begin
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (cx == '0) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (active) begin
            if (bar_cnt_q == BCW'(BAR_W - 1)) begin
                bar_cnt_d = '0;
                if (bar_idx_q != 3'd7) begin
                    bar_idx_d = bar_idx_q + 3'd1;
                end
            end else begin
                bar_cnt_d = bar_cnt_q + BCW'(1);
            end
        end
    end

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx_d)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        pat = 24'h000000;
        case (mode_active_q)
            3'd0: pat = SOLID_RGB;
            3'd1: pat = bar_rgb;
            3'd2: begin
                if (cy < BIT_HEIGHT'(BAND_H)) begin
                    pat = 24'hFF0000;
                end else if (cy < BIT_HEIGHT'(2 * BAND_H)) begin
                    pat = 24'h00FF00;
                end else begin
                    pat = 24'h0000FF;
                end
            end
            3'd3: begin
                if (cx[CHECK_LOG2] ^ cy[CHECK_LOG2] ^ frame_cnt_q[6]) begin
                    pat = 24'hFFFFFF;
                end
            end
            3'd4: begin
                if (cx == '0) begin
                    pat = 24'hFF0000;
                end else if (cy == '0) begin
                    pat = 24'h00FF00;
                end else if ((cx == screen_width - BIT_WIDTH'(1))
                          || (cy == screen_height - BIT_HEIGHT'(1))) begin
                    pat = 24'h0000FF;
                end
            end
            3'd5:    pat = in_box ? 24'h00FFFF : 24'h202020;
            3'd6:    pat = {cx[7:0], cx[7:0], cx[7:0]};
            default: pat = 24'h000000;
        endcase

        rgb_d = active ? pat : 24'h000000;
`ifdef HDMI_PATTERN_GEN_CROSSHAIR_EN
        if (active && ((cx == (screen_width >> 1))
                    || (cy == (screen_height >> 1)))) begin
            rgb_d = 24'hFFFFFF;
        end
`endif
    end

    // Frame-synchronous state: counter, mode latch and box motion.
    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        mode_active_d = mode_active_q;
        box_x_d       = box_x_q;
        box_y_d       = box_y_q;
        dir_x_d       = dir_x_q;
        dir_y_d       = dir_y_q;
        if (frame_end) begin
            frame_cnt_d   = frame_cnt_q + 16'd1;
            mode_active_d = mode;

            if (!dir_x_q) begin
                if (box_x_e + WX'(BOX_STEP) + WX'(BOX_SIZE) >= sw_e) begin
                    box_x_d = screen_width - BIT_WIDTH'(BOX_SIZE);
                    dir_x_d = 1'b1;
                end else begin
                    box_x_d = box_x_q + BIT_WIDTH'(BOX_STEP);
                end
            end else if (box_x_q < BIT_WIDTH'(BOX_STEP)) begin
                box_x_d = '0;
                dir_x_d = 1'b0;
            end else begin
                box_x_d = box_x_q - BIT_WIDTH'(BOX_STEP);
            end

            if (!dir_y_q) begin
                if (box_y_e + WY'(BOX_STEP) + WY'(BOX_SIZE) >= sh_e) begin
                    box_y_d = screen_height - BIT_HEIGHT'(BOX_SIZE);
                    dir_y_d = 1'b1;
                end else begin
                    box_y_d = box_y_q + BIT_HEIGHT'(BOX_STEP);
                end
            end else if (box_y_q < BIT_HEIGHT'(BOX_STEP)) begin
                box_y_d = '0;
                dir_y_d = 1'b0;
            end else begin
                box_y_d = box_y_q - BIT_HEIGHT'(BOX_STEP);
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            rgb_q         <= '0;
            frame_cnt_q   <= '0;
            mode_active_q <= '0;
            box_x_q       <= '0;
            box_y_q       <= '0;
            dir_x_q       <= 1'b0;
            dir_y_q       <= 1'b0;
            bar_cnt_q     <= '0;
            bar_idx_q     <= '0;
        end else begin
            rgb_q         <= rgb_d;
            frame_cnt_q   <= frame_cnt_d;
            mode_active_q <= mode_active_d;
            box_x_q       <= box_x_d;
            box_y_q       <= box_y_d;
            dir_x_q       <= dir_x_d;
            dir_y_q       <= dir_y_d;
            bar_cnt_q     <= bar_cnt_d;
            bar_idx_q     <= bar_idx_d;
        end
    end

    assign rgb         = rgb_q;
    assign frame_cnt   = frame_cnt_q;
    assign mode_active = mode_active_q;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// tb_hdmi_pattern_gen: directed + randomized bench for hdmi_pattern_gen.
// Expected pixels come from a frame-level reference model.
module tb_hdmi_pattern_gen;

    localparam int SW = 1280;
    localparam int SH = 720;
    localparam int FW = 1650;
    localparam int FH = 750;

    logic        clk;
    logic        reset;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic [2:0]  mode;
    logic [23:0] rgb;
    logic [15:0] frame_cnt;
    logic [2:0]  mode_active;

    int nchk;
    int nerr;

    int m_fc;
    int m_mode;
    int m_bx;
    int m_by;
    int m_dx;
    int m_dy;

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
                                 24'h00FF00, 24'hFF00FF, 24'hFF0000,
                                 24'h0000FF, 24'h000000};

    hdmi_pattern_gen dut (
        .clk_pixel     (clk),
        .reset         (reset),
        .cx            (cx),
        .cy            (cy),
        .screen_width  (11'(SW)),
        .screen_height (10'(SH)),
        .frame_width   (11'(FW)),
        .frame_height  (10'(FH)),
        .mode          (mode),
        .rgb           (rgb),
        .frame_cnt     (frame_cnt),
        .mode_active   (mode_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] exp_pix(int x, int y);
        int b;
        if (!(x < SW && y < SH)) return 24'h000000;
`ifdef HDMI_PATTERN_GEN_CROSSHAIR_EN
        if (x == SW / 2 || y == SH / 2) return 24'hFFFFFF;
`endif
        case (m_mode)
            0: return 24'hFF0000;
            1: begin
                b = x / 160;
                if (b > 7) b = 7;
                return bar_tab[b];
            end
            2: begin
                if (y < 240) return 24'hFF0000;
                if (y < 480) return 24'h00FF00;
                return 24'h0000FF;
            end
            3: return (((x / 32) + (y / 32) + (m_fc / 64)) % 2 == 1)
                      ? 24'hFFFFFF : 24'h000000;
            4: begin
                if (x == 0) return 24'hFF0000;
                if (y == 0) return 24'h00FF00;
                if (x == SW - 1 || y == SH - 1) return 24'h0000FF;
                return 24'h000000;
            end
            5: return (x >= m_bx && x < m_bx + 64 && y >= m_by && y < m_by + 64)
                      ? 24'h00FFFF : 24'h202020;
            6: return 24'((x % 256) * 32'h010101);
            default: return 24'h000000;
        endcase
    endfunction

    function automatic void bounce(inout int p, inout int d, input int lim);
        if (d > 0) begin
            if (p + 4 + 64 >= lim) begin
                p = lim - 64;
                d = -1;
            end else begin
                p = p + 4;
            end
        end else if (p < 4) begin
            p = 0;
            d = 1;
        end else begin
            p = p - 4;
        end
    endfunction

    task automatic model_reset();
        m_fc   = 0;
        m_mode = 0;
        m_bx   = 0;
        m_by   = 0;
        m_dx   = 1;
        m_dy   = 1;
    endtask

    task automatic chk_val(string tag, logic [31:0] obs, logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(int x, int y, bit chk);
        logic [23:0] e;
        bit          fe;
        cx = 11'(x);
        cy = 10'(y);
        e  = exp_pix(x, y);
        fe = (x == FW - 1) && (y == FH - 1);
        @(posedge clk);
        #1;
        if (chk) begin
            nchk++;
            assert (rgb === e) else begin
                nerr++;
                $error("FAIL pix(%0d,%0d) observed=%h expected=%h",
                       x, y, rgb, e);
            end
        end
        if (fe) begin
            m_fc   = (m_fc + 1) % 65536;
            m_mode = int'(mode);
            bounce(m_bx, m_dx, SW);
            bounce(m_by, m_dy, SH);
        end
    endtask

    task automatic frame_end(bit chk);
        step(FW - 1, FH - 1, chk);
    endtask

    int          dxs [5] = '{0, 159, 160, 1279, 1280};
    logic [23:0] dvs [5] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00,
                             24'h000000, 24'h000000};

    initial begin
        nchk  = 0;
        nerr  = 0;
        reset = 1'b1;
        cx    = '0;
        cy    = '0;
        mode  = 3'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_val("reset_rgb", 32'(rgb), 32'h0);
        chk_val("reset_fc", 32'(frame_cnt), 32'h0);
        chk_val("reset_mode", 32'(mode_active), 32'h0);
        reset = 1'b0;

        // Box flight and frame counter wrap from reset.
        mode = 3'd5;
        for (int n = 1; n <= 65536; n++) begin
            frame_end(n <= 305);
            if (n == 1) chk_val("mode_latch", 32'(mode_active), 32'd5);
            if (n == 3) chk_val("fc_3", 32'(frame_cnt), 32'd3);
            if (n == 304) begin
                step(1216, m_by, 1'b1);
                chk_val("box304_in", 32'(rgb), 32'h00FFFF);
                step(1215, m_by, 1'b1);
                chk_val("box304_out", 32'(rgb), 32'h202020);
            end
            if (n == 305) begin
                step(1212, m_by, 1'b1);
                chk_val("box305_in", 32'(rgb), 32'h00FFFF);
                step(1276, m_by, 1'b1);
                chk_val("box305_out", 32'(rgb), 32'h202020);
            end
            if (n == 65535) chk_val("fc_ffff", 32'(frame_cnt), 32'hFFFF);
        end
        chk_val("fc_wrap", 32'(frame_cnt), 32'h0);

        // Colour bars along row 10, running into blanking.
        mode = 3'd1;
        frame_end(1'b1);
        for (int x = 0; x <= 1300; x++) begin
            step(x, 10, 1'b1);
            for (int k = 0; k < 5; k++) begin
                if (x == dxs[k]) chk_val("bars", 32'(rgb), 32'(dvs[k]));
            end
        end

        // Mode request mid-frame must not tear.
        mode = 3'd0;
        frame_end(1'b1);
        step(5, 299, 1'b1);
        mode = 3'd2;
        step(5, 300, 1'b1);
        chk_val("no_tear_a", 32'(rgb), 32'hFF0000);
        step(1279, 719, 1'b1);
        chk_val("no_tear_b", 32'(rgb), 32'hFF0000);
        frame_end(1'b1);
        chk_val("mode2_act", 32'(mode_active), 32'd2);
        step(10, 0, 1'b1);
        chk_val("band0", 32'(rgb), 32'hFF0000);
        step(10, 250, 1'b1);
        chk_val("band1", 32'(rgb), 32'h00FF00);
        step(10, 500, 1'b1);
        chk_val("band2", 32'(rgb), 32'h0000FF);

        // Border.
        mode = 3'd4;
        frame_end(1'b1);
        step(0, 0, 1'b1);
        chk_val("border_00", 32'(rgb), 32'hFF0000);
        step(5, 0, 1'b1);
        chk_val("border_50", 32'(rgb), 32'h00FF00);
        step(1279, 5, 1'b1);
        chk_val("border_r", 32'(rgb), 32'h0000FF);
        step(5, 719, 1'b1);
        chk_val("border_b", 32'(rgb), 32'h0000FF);
        step(640, 360, 1'b1);
`ifdef HDMI_PATTERN_GEN_CROSSHAIR_EN
        chk_val("border_mid", 32'(rgb), 32'hFFFFFF);
        step(640, 100, 1'b1);
        chk_val("crosshair", 32'(rgb), 32'hFFFFFF);
`else
        chk_val("border_mid", 32'(rgb), 32'h000000);
`endif

        // Random modes and rows against the model.
        for (int it = 0; it < 4; it++) begin
            int y;
            mode = 3'($urandom_range(0, 7));
            frame_end(1'b1);
            chk_val("rand_mode", 32'(mode_active), 32'(m_mode));
            y = int'($urandom_range(0, FH - 1));
            for (int x = 0; x <= 1300; x++) step(x, y, 1'b1);
        end

        // Asynchronous reset mid-frame while showing the checker.
        mode = 3'd3;
        frame_end(1'b1);
        step(700, 400, 1'b1);
        reset = 1'b1;
        #1;
        chk_val("arst_rgb", 32'(rgb), 32'h0);
        chk_val("arst_fc", 32'(frame_cnt), 32'h0);
        chk_val("arst_mode", 32'(mode_active), 32'h0);
        #2;
        reset = 1'b0;
        model_reset();
        step(10, 10, 1'b1);
        chk_val("post_rst_a", 32'(rgb), 32'hFF0000);
        step(100, 200, 1'b1);
        chk_val("post_rst_b", 32'(rgb), 32'hFF0000);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
